param_stack: RTL and testbench

- Parametrised LIFO stack for register save/restore in the CPU.
- Generalises the fixed 32x128 stack:
  - configurable width and depth
  - full/empty/count status
  - sticky overflow/underflow error flags
  - high-water mark
  - registered top-of-stack output that is defined (zero) when empty.
- Sits beside the register file; pushes and pops are driven by the decoder's push/pop instructions.

---
 rtl/stack_pkg.sv | 25 ++
 rtl/stack_ram.sv | 26 ++
 rtl/param_stack.sv | 161 ++++++++++++++++
 tb/tb_param_stack.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared defaults and operation decode for the parametrised LIFO stack.
package stack_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 128;

  localparam logic [1:0] OP_IDLE = 2'd0;
  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd2;
  localparam logic [1:0] OP_REPL = 2'd3;

  // push+pop on an empty stack has nothing to replace, so it degrades to a push
  function automatic logic [1:0] decode_op(input logic push_i, input logic pop_i,
                                           input logic cnt_zero_i);
    logic [1:0] op;
    case ({push_i, pop_i})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = cnt_zero_i ? OP_PUSH : OP_REPL;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module stack_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; count tracks validity.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO with status, sticky errors and high-water mark.
// Optional STACK_ERR_IRQ_EN adds a one-cycle err_irq pulse on every dropped push / ignored pop.
module param_stack
  import stack_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d,
  input  logic              push,
  input  logic              pop,
  output logic [DATA_W-1:0] q,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  hwm,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clear,
  output logic              err_irq
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] q_q, q_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  hwm_q, hwm_d;
  logic              empty_q, full_q;
  logic              overflow_q, underflow_q;
  logic              ovf_set_s, unf_set_s;
  logic              we_s;
  logic [AW-1:0]     waddr_s;
  logic [AW-1:0]     raddr_s;
  logic [DATA_W-1:0] rdata_s;
  logic [1:0]        op_s;

  assign op_s = decode_op(push, pop, empty_q);

  // Modular arithmetic on the low bits is exact whenever the pointer is used (count >= 2).
  assign raddr_s = count_q[AW-1:0] - AW'(2);

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (we_s),
    .waddr_i (waddr_s),
    .wdata_i (d),
    .raddr_i (raddr_s),
    .rdata_o (rdata_s)
  );

  // Next-state decode of count, top-of-stack, memory write and error events.
  always_comb begin
    count_d   = count_q;
    q_d       = q_q;
    we_s      = 1'b0;
    waddr_s   = count_q[AW-1:0];
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    case (op_s)
      OP_PUSH: begin
        if (full_q) begin
          ovf_set_s = 1'b1;
        end else begin
          we_s    = 1'b1;
          waddr_s = count_q[AW-1:0];
          count_d = count_q + CNT_W'(1);
          q_d     = d;
        end
      end
      OP_POP: begin
        if (empty_q) begin
          unf_set_s = 1'b1;
        end else if (count_q == CNT_W'(1)) begin
          count_d = {CNT_W{1'b0}};
          q_d     = {DATA_W{1'b0}};
        end else begin
          count_d = count_q - CNT_W'(1);
          q_d     = rdata_s;
        end
      end
      OP_REPL: begin
        we_s    = 1'b1;
        waddr_s = count_q[AW-1:0] - AW'(1);
        q_d     = d;
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // err_clear wins over growth: hwm restarts from the count being written this cycle.
  always_comb begin
    if (err_clear) begin
      hwm_d = count_d;
    end else if (count_d > hwm_q) begin
      hwm_d = count_d;
    end else begin
      hwm_d = hwm_q;
    end
  end

  // Registered state and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= {CNT_W{1'b0}};
      q_q         <= {DATA_W{1'b0}};
      hwm_q       <= {CNT_W{1'b0}};
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      q_q     <= q_d;
      hwm_q   <= hwm_d;
      empty_q <= (count_d == {CNT_W{1'b0}});
      full_q  <= (count_d == CNT_W'(DEPTH));
      if (err_clear) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        overflow_q  <= overflow_q | ovf_set_s;
        underflow_q <= underflow_q | unf_set_s;
      end
    end
  end

`ifdef STACK_ERR_IRQ_EN
  logic err_irq_q;

  // Pulse follows every error event regardless of sticky flags or err_clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_irq_q <= 1'b0;
    end else begin
      err_irq_q <= ovf_set_s | unf_set_s;
    end
  end

  assign err_irq = err_irq_q;
`else
  assign err_irq = 1'b0;
`endif

  assign q         = q_q;
  assign count     = count_q;
  assign hwm       = hwm_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_param_stack.sv
// Directed self-checking bench for param_stack with DATA_W=32, DEPTH=4.
module tb_param_stack;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
`ifdef STACK_ERR_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] d = '0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic              err_clear = 1'b0;
  logic [DATA_W-1:0] q;
  logic              empty, full, overflow, underflow, err_irq;
  logic [CNT_W-1:0]  count, hwm;

  int n_checks = 0;
  int n_fail   = 0;

  param_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .d(d), .push(push), .pop(pop), .q(q),
    .empty(empty), .full(full), .count(count), .hwm(hwm),
    .overflow(overflow), .underflow(underflow), .err_clear(err_clear), .err_irq(err_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic ps, input logic pp, input logic [DATA_W-1:0] dv);
    push = ps; pop = pp; d = dv;
    tick();
    push = 1'b0; pop = 1'b0; d = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (q !== 32'h0)       begin n_fail++; $display("FAIL reset_q got=%h exp=0", q); end
    n_checks++; if (count !== 3'd0)    begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_checks++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_checks++; if (full !== 1'b0)     begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_checks++; if (hwm !== 3'd0)      begin n_fail++; $display("FAIL reset_hwm got=%0d exp=0", hwm); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_unf got=%b exp=0", underflow); end
    n_checks++; if (err_irq !== 1'b0)  begin n_fail++; $display("FAIL reset_irq got=%b exp=0", err_irq); end
  endtask

  task automatic test_underflow();
    do_op(1'b0, 1'b1, 32'h0);
    n_checks++; if (q !== 32'h0)        begin n_fail++; $display("FAIL unf_q got=%h exp=0", q); end
    n_checks++; if (count !== 3'd0)     begin n_fail++; $display("FAIL unf_count got=%0d exp=0", count); end
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_flag got=%b exp=1", underflow); end
    n_checks++; if (err_irq !== IRQ_EN) begin n_fail++; $display("FAIL unf_irq got=%b exp=%b", err_irq, IRQ_EN); end
    tick();
    n_checks++; if (err_irq !== 1'b0)   begin n_fail++; $display("FAIL unf_irq_end got=%b exp=0", err_irq); end
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_sticky got=%b exp=1", underflow); end
  endtask

  task automatic test_push_full();
    logic [DATA_W-1:0] vals [4] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, 1'b0, vals[i]);
      n_checks++; if (q !== vals[i]) begin n_fail++; $display("FAIL push_q[%0d] got=%h exp=%h", i, q, vals[i]); end
      n_checks++; if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL push_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
    end
    n_checks++; if (full !== 1'b1)  begin n_fail++; $display("FAIL push_full got=%b exp=1", full); end
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL push_empty got=%b exp=0", empty); end
    do_op(1'b1, 1'b0, 32'hFF);
    n_checks++; if (overflow !== 1'b1)  begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    n_checks++; if (q !== 32'hA4)       begin n_fail++; $display("FAIL ovf_q got=%h exp=a4", q); end
    n_checks++; if (count !== 3'd4)     begin n_fail++; $display("FAIL ovf_count got=%0d exp=4", count); end
    n_checks++; if (err_irq !== IRQ_EN) begin n_fail++; $display("FAIL ovf_irq got=%b exp=%b", err_irq, IRQ_EN); end
  endtask

  task automatic test_pop_drain();
    logic [DATA_W-1:0] exp_q [4] = '{32'hA3, 32'hA2, 32'hA1, 32'h0};
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, 1'b1, 32'h0);
      n_checks++; if (q !== exp_q[i]) begin n_fail++; $display("FAIL pop_q[%0d] got=%h exp=%h", i, q, exp_q[i]); end
      n_checks++; if (count !== 3'(3 - i)) begin n_fail++; $display("FAIL pop_count[%0d] got=%0d exp=%0d", i, count, 3 - i); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pop_empty got=%b exp=1", empty); end
    n_checks++; if (full !== 1'b0)  begin n_fail++; $display("FAIL pop_full got=%b exp=0", full); end
    n_checks++; if (hwm !== 3'd4)   begin n_fail++; $display("FAIL pop_hwm got=%0d exp=4", hwm); end
  endtask

  task automatic test_replace();
    do_op(1'b1, 1'b0, 32'hB1);
    do_op(1'b1, 1'b0, 32'hB2);
    do_op(1'b1, 1'b1, 32'hC0);
    n_checks++; if (q !== 32'hC0)   begin n_fail++; $display("FAIL repl_q got=%h exp=c0", q); end
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL repl_count got=%0d exp=2", count); end
    do_op(1'b0, 1'b1, 32'h0);
    n_checks++; if (q !== 32'hB1)   begin n_fail++; $display("FAIL repl_pop_q got=%h exp=b1", q); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL repl_pop_count got=%0d exp=1", count); end
  endtask

  task automatic test_repl_empty();
    do_reset();
    do_op(1'b1, 1'b1, 32'h55);
    n_checks++; if (count !== 3'd1)     begin n_fail++; $display("FAIL repl_empty_count got=%0d exp=1", count); end
    n_checks++; if (q !== 32'h55)       begin n_fail++; $display("FAIL repl_empty_q got=%h exp=55", q); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL repl_empty_unf got=%b exp=0", underflow); end
    n_checks++; if (err_irq !== 1'b0)   begin n_fail++; $display("FAIL repl_empty_irq got=%b exp=0", err_irq); end
    do_op(1'b0, 1'b1, 32'h0);
    n_checks++; if (q !== 32'h0)        begin n_fail++; $display("FAIL repl_empty_pop_q got=%h exp=0", q); end
  endtask

  task automatic test_err_clear();
    do_reset();
    for (int i = 0; i < 4; i++) do_op(1'b1, 1'b0, 32'(32'h10 + i));
    do_op(1'b1, 1'b0, 32'hEE);
    do_op(1'b0, 1'b1, 32'h0);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_pre_ovf got=%b exp=1", overflow); end
    n_checks++; if (q !== 32'h12)      begin n_fail++; $display("FAIL clr_pre_q got=%h exp=12", q); end
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got=%b exp=0", overflow); end
    n_checks++; if (hwm !== 3'd3)      begin n_fail++; $display("FAIL clr_hwm got=%0d exp=3", hwm); end
    do_op(1'b1, 1'b0, 32'h13);
    // Error raised in the same cycle as err_clear is lost from the sticky flag.
    err_clear = 1'b1; do_op(1'b1, 1'b0, 32'hDD); err_clear = 1'b0;
    n_checks++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL clr_same_ovf got=%b exp=0", overflow); end
    n_checks++; if (hwm !== 3'd4)       begin n_fail++; $display("FAIL clr_same_hwm got=%0d exp=4", hwm); end
    n_checks++; if (err_irq !== IRQ_EN) begin n_fail++; $display("FAIL clr_same_irq got=%b exp=%b", err_irq, IRQ_EN); end
    do_op(1'b1, 1'b1, 32'h77);
    n_checks++; if (q !== 32'h77)      begin n_fail++; $display("FAIL full_repl_q got=%h exp=77", q); end
    n_checks++; if (count !== 3'd4)    begin n_fail++; $display("FAIL full_repl_count got=%0d exp=4", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_repl_ovf got=%b exp=0", overflow); end
    do_op(1'b0, 1'b1, 32'h0);
    n_checks++; if (q !== 32'h12)      begin n_fail++; $display("FAIL full_repl_pop_q got=%h exp=12", q); end
  endtask

  task automatic test_reset_mid();
    do_op(1'b1, 1'b0, 32'h99);
    push = 1'b1; d = 32'h44; reset = 1'b1;
    tick();
    push = 1'b0; d = '0; reset = 1'b0;
    n_checks++; if (count !== 3'd0)  begin n_fail++; $display("FAIL mid_count got=%0d exp=0", count); end
    n_checks++; if (q !== 32'h0)     begin n_fail++; $display("FAIL mid_q got=%h exp=0", q); end
    n_checks++; if (empty !== 1'b1)  begin n_fail++; $display("FAIL mid_empty got=%b exp=1", empty); end
    n_checks++; if (full !== 1'b0)   begin n_fail++; $display("FAIL mid_full got=%b exp=0", full); end
    n_checks++; if (hwm !== 3'd0)    begin n_fail++; $display("FAIL mid_hwm got=%0d exp=0", hwm); end
  endtask

  task automatic test_back_to_back();
    do_op(1'b1, 1'b0, 32'h10);
    do_op(1'b1, 1'b0, 32'h20);
    do_op(1'b0, 1'b1, 32'h0);
    n_checks++; if (q !== 32'h10)   begin n_fail++; $display("FAIL b2b_pop1_q got=%h exp=10", q); end
    do_op(1'b1, 1'b0, 32'h30);
    n_checks++; if (q !== 32'h30)   begin n_fail++; $display("FAIL b2b_push_q got=%h exp=30", q); end
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", count); end
    do_op(1'b0, 1'b1, 32'h0);
    n_checks++; if (q !== 32'h10)   begin n_fail++; $display("FAIL b2b_pop2_q got=%h exp=10", q); end
    do_op(1'b0, 1'b1, 32'h0);
    n_checks++; if (q !== 32'h0)    begin n_fail++; $display("FAIL b2b_pop3_q got=%h exp=0", q); end
    n_checks++; if (hwm !== 3'd2)   begin n_fail++; $display("FAIL b2b_hwm got=%0d exp=2", hwm); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL b2b_unf got=%b exp=0", underflow); end
  endtask

  initial begin
    test_reset();
    test_underflow();
    test_push_full();
    test_pop_drain();
    test_replace();
    test_repl_empty();
    test_err_clear();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
